// File: rtl/multicycle_control.sv
// Main control FSM of the 8-bit multicycle MIPS datapath (Moore, one state per clock).
// Define MULTICYCLE_ADDI_EN to add the ADDI_EX/ADDI_WB states for opcode 001000.
module multicycle_control (
   input  logic       clock,
   input  logic       resetN,
   input  logic [5:0] opcode,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       IorD,
   output logic       memRead,
   output logic       memWrite,
   output logic       IRWrite,
   output logic       memToReg,
   output logic       regDst,
   output logic       writeDataSignal,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [1:0] PCSource,
   output logic       illegalOp,
   output logic [3:0] state
);

   localparam int unsigned StateW = 4;
   localparam int unsigned OpW    = 6;

   localparam logic [OpW-1:0] OpRtype = 6'b000000;
   localparam logic [OpW-1:0] OpLw    = 6'b100011;
   localparam logic [OpW-1:0] OpSw    = 6'b101011;
   localparam logic [OpW-1:0] OpBeq   = 6'b000100;
   localparam logic [OpW-1:0] OpJ     = 6'b000010;
`ifdef MULTICYCLE_ADDI_EN
   localparam logic [OpW-1:0] OpAddi  = 6'b001000;
`endif

   typedef enum logic [StateW-1:0] {
      START     = 4'd0,
      FETCH     = 4'd1,
      DECODE    = 4'd2,
      MEM_ADDR  = 4'd3,
      MEM_READ  = 4'd4,
      MEM_WB    = 4'd5,
      MEM_WRITE = 4'd6,
      R_EXEC    = 4'd7,
      R_WB      = 4'd8,
      BRANCH    = 4'd9,
`ifdef MULTICYCLE_ADDI_EN
      JUMP      = 4'd10,
      ADDI_EX   = 4'd11,
      ADDI_WB   = 4'd12
`else
      JUMP      = 4'd10
`endif
   } state_e;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
   } ctrl_t;

   state_e state_q, state_d;
   ctrl_t  ctrl_q, ctrl_d;
   logic   illegal_q, illegal_d;

   // State and control registers; controls are decoded from the next state so they
   // line up with state_q and clear immediately on reset.
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         state_q   <= START;
         ctrl_q    <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ctrl_q    <= ctrl_d;
         illegal_q <= illegal_d;
      end
   end

   // Next-state logic; unknown opcodes and unused codes fall back to FETCH.
   always_comb begin
      state_d   = FETCH;
      illegal_d = 1'b0;
      case (state_q)
         START:    state_d = FETCH;
         FETCH:    state_d = DECODE;
         DECODE: begin
            case (opcode)
               OpRtype:    state_d = R_EXEC;
               OpLw, OpSw: state_d = MEM_ADDR;
               OpBeq:      state_d = BRANCH;
               OpJ:        state_d = JUMP;
`ifdef MULTICYCLE_ADDI_EN
               OpAddi:     state_d = ADDI_EX;
`endif
               default: begin
                  state_d   = FETCH;
                  illegal_d = 1'b1;
               end
            endcase
         end
         MEM_ADDR: begin
            if (opcode == OpLw)      state_d = MEM_READ;
            else if (opcode == OpSw) state_d = MEM_WRITE;
            else                     state_d = FETCH;
         end
         MEM_READ: state_d = MEM_WB;
         R_EXEC:   state_d = R_WB;
`ifdef MULTICYCLE_ADDI_EN
         ADDI_EX:  state_d = ADDI_WB;
`endif
         default:  state_d = FETCH;
      endcase
   end

   // Control decode of the state being entered.
   always_comb begin
      ctrl_d = '0;
      case (state_d)
         FETCH: begin
            ctrl_d.mem_read  = 1'b1;
            ctrl_d.ir_write  = 1'b1;
            ctrl_d.alu_src_b = 2'b01;
            ctrl_d.pc_write  = 1'b1;
         end
         DECODE:   ctrl_d.alu_src_b = 2'b11;
         MEM_ADDR: begin
            ctrl_d.alu_src_a = 1'b1;
            ctrl_d.alu_src_b = 2'b10;
         end
         MEM_READ: begin
            ctrl_d.mem_read = 1'b1;
            ctrl_d.i_or_d   = 1'b1;
         end
         MEM_WB: begin
            ctrl_d.reg_write  = 1'b1;
            ctrl_d.mem_to_reg = 1'b1;
         end
         MEM_WRITE: begin
            ctrl_d.mem_write = 1'b1;
            ctrl_d.i_or_d    = 1'b1;
         end
         R_EXEC: begin
            ctrl_d.alu_src_a = 1'b1;
            ctrl_d.alu_op    = 2'b10;
         end
         R_WB: begin
            ctrl_d.reg_write = 1'b1;
            ctrl_d.reg_dst   = 1'b1;
         end
         BRANCH: begin
            ctrl_d.alu_src_a     = 1'b1;
            ctrl_d.alu_op        = 2'b01;
            ctrl_d.pc_write_cond = 1'b1;
            ctrl_d.pc_source     = 2'b01;
         end
         JUMP: begin
            ctrl_d.pc_write  = 1'b1;
            ctrl_d.pc_source = 2'b10;
         end
`ifdef MULTICYCLE_ADDI_EN
         ADDI_EX: begin
            ctrl_d.alu_src_a = 1'b1;
            ctrl_d.alu_src_b = 2'b10;
         end
         ADDI_WB:  ctrl_d.reg_write = 1'b1;
`endif
         default:  ctrl_d = '0;
      endcase
   end

   assign PCWrite         = ctrl_q.pc_write;
   assign PCWriteCond     = ctrl_q.pc_write_cond;
   assign IorD            = ctrl_q.i_or_d;
   assign memRead         = ctrl_q.mem_read;
   assign memWrite        = ctrl_q.mem_write;
   assign IRWrite         = ctrl_q.ir_write;
   assign memToReg        = ctrl_q.mem_to_reg;
   assign regDst          = ctrl_q.reg_dst;
   assign writeDataSignal = ctrl_q.reg_write;
   assign ALUSrcA         = ctrl_q.alu_src_a;
   assign ALUSrcB         = ctrl_q.alu_src_b;
   assign ALUOp           = ctrl_q.alu_op;
   assign PCSource        = ctrl_q.pc_source;
   assign illegalOp       = illegal_q;
   assign state           = StateW'(state_q);

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: state sequences and Moore outputs per instruction class.
module tb_multicycle_control;

   logic       clock;
   logic       resetN;
   logic [5:0] opcode;
   logic       PCWrite, PCWriteCond, IorD, memRead, memWrite, IRWrite;
   logic       memToReg, regDst, writeDataSignal, ALUSrcA, illegalOp;
   logic [1:0] ALUSrcB, ALUOp, PCSource;
   logic [3:0] state;

   int n_checks = 0;
   int n_fail   = 0;

   multicycle_control dut (
      .clock(clock), .resetN(resetN), .opcode(opcode),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
      .memRead(memRead), .memWrite(memWrite), .IRWrite(IRWrite),
      .memToReg(memToReg), .regDst(regDst), .writeDataSignal(writeDataSignal),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
      .illegalOp(illegalOp), .state(state)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // {PCWrite,PCWriteCond,IorD,memRead,memWrite,IRWrite,memToReg,regDst,wds,ALUSrcA,ALUSrcB,ALUOp,PCSource,illegalOp}
   logic [16:0] outs;
   assign outs = {PCWrite, PCWriteCond, IorD, memRead, memWrite, IRWrite, memToReg, regDst,
                  writeDataSignal, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegalOp};

   localparam logic [16:0] O_ZERO   = 17'b0000000000_00_00_00_0;
   localparam logic [16:0] O_FETCH  = 17'b1001010000_01_00_00_0;
   localparam logic [16:0] O_FETCHI = 17'b1001010000_01_00_00_1;
   localparam logic [16:0] O_DECODE = 17'b0000000000_11_00_00_0;
   localparam logic [16:0] O_MADDR  = 17'b0000000001_10_00_00_0;
   localparam logic [16:0] O_MREAD  = 17'b0011000000_00_00_00_0;
   localparam logic [16:0] O_MWB    = 17'b0000001010_00_00_00_0;
   localparam logic [16:0] O_MWRITE = 17'b0010100000_00_00_00_0;
   localparam logic [16:0] O_REXEC  = 17'b0000000001_00_10_00_0;
   localparam logic [16:0] O_RWB    = 17'b0000000110_00_00_00_0;
   localparam logic [16:0] O_BRANCH = 17'b0100000001_00_01_01_0;
   localparam logic [16:0] O_JUMP   = 17'b1000000000_00_00_10_0;
   localparam logic [16:0] O_ADDIWB = 17'b0000000010_00_00_00_0;

   task automatic test_reset();
      resetN = 1'b0;
      opcode = 6'b000000;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         n_checks++;
         if (state !== 4'd0 || outs !== O_ZERO) begin
            n_fail++;
            $display("FAIL reset_hold cyc%0d: state=%0d outs=%b, expected state=0 outs=%b", i, state, outs, O_ZERO);
         end
      end
      resetN = 1'b1;
      @(negedge clock);
      n_checks++;
      if (state !== 4'd1 || outs !== O_FETCH) begin
         n_fail++;
         $display("FAIL reset_release: state=%0d outs=%b, expected state=1 outs=%b", state, outs, O_FETCH);
      end
   endtask

   task automatic test_rtype();
      logic [3:0]  es [4];
      logic [16:0] eo [4];
      es = '{4'd2, 4'd7, 4'd8, 4'd1};
      eo = '{O_DECODE, O_REXEC, O_RWB, O_FETCH};
      opcode = 6'b000000;
      for (int i = 0; i < 4; i++) begin
         @(posedge clock); @(negedge clock);
         n_checks++;
         if (state !== es[i] || outs !== eo[i]) begin
            n_fail++;
            $display("FAIL rtype step%0d: state=%0d outs=%b, expected state=%0d outs=%b", i, state, outs, es[i], eo[i]);
         end
      end
   endtask

   task automatic test_lw_sw();
      logic [3:0]  es [5];
      logic [16:0] eo [5];
      logic [3:0]  ss [4];
      logic [16:0] so [4];
      es = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd1};
      eo = '{O_DECODE, O_MADDR, O_MREAD, O_MWB, O_FETCH};
      ss = '{4'd2, 4'd3, 4'd6, 4'd1};
      so = '{O_DECODE, O_MADDR, O_MWRITE, O_FETCH};
      opcode = 6'b100011;
      for (int i = 0; i < 5; i++) begin
         @(posedge clock); @(negedge clock);
         n_checks++;
         if (state !== es[i] || outs !== eo[i]) begin
            n_fail++;
            $display("FAIL lw step%0d: state=%0d outs=%b, expected state=%0d outs=%b", i, state, outs, es[i], eo[i]);
         end
      end
      opcode = 6'b101011;
      for (int i = 0; i < 4; i++) begin
         @(posedge clock); @(negedge clock);
         n_checks++;
         if (state !== ss[i] || outs !== so[i]) begin
            n_fail++;
            $display("FAIL sw step%0d: state=%0d outs=%b, expected state=%0d outs=%b", i, state, outs, ss[i], so[i]);
         end
      end
   endtask

   task automatic test_beq();
      logic [3:0]  es [3];
      logic [16:0] eo [3];
      es = '{4'd2, 4'd9, 4'd1};
      eo = '{O_DECODE, O_BRANCH, O_FETCH};
      opcode = 6'b000100;
      for (int i = 0; i < 3; i++) begin
         @(posedge clock); @(negedge clock);
         n_checks++;
         if (state !== es[i] || outs !== eo[i]) begin
            n_fail++;
            $display("FAIL beq step%0d: state=%0d outs=%b, expected state=%0d outs=%b", i, state, outs, es[i], eo[i]);
         end
      end
   endtask

   // Illegal opcode followed by j: the pulse must clear after one FETCH cycle.
   task automatic test_illegal_then_jump();
      logic [3:0]  es [5];
      logic [16:0] eo [5];
      es = '{4'd2, 4'd1, 4'd2, 4'd10, 4'd1};
      eo = '{O_DECODE, O_FETCHI, O_DECODE, O_JUMP, O_FETCH};
      opcode = 6'b111111;
      for (int i = 0; i < 5; i++) begin
         if (i == 2) opcode = 6'b000010;
         @(posedge clock); @(negedge clock);
         n_checks++;
         if (state !== es[i] || outs !== eo[i]) begin
            n_fail++;
            $display("FAIL illegal_j step%0d: state=%0d outs=%b, expected state=%0d outs=%b", i, state, outs, es[i], eo[i]);
         end
      end
   endtask

   task automatic test_addi();
`ifdef MULTICYCLE_ADDI_EN
      logic [3:0]  es [4];
      logic [16:0] eo [4];
      es = '{4'd2, 4'd11, 4'd12, 4'd1};
      eo = '{O_DECODE, O_MADDR, O_ADDIWB, O_FETCH};
      opcode = 6'b001000;
      for (int i = 0; i < 4; i++) begin
`else
      logic [3:0]  es [2];
      logic [16:0] eo [2];
      es = '{4'd2, 4'd1};
      eo = '{O_DECODE, O_FETCHI};
      opcode = 6'b001000;
      for (int i = 0; i < 2; i++) begin
`endif
         @(posedge clock); @(negedge clock);
         n_checks++;
         if (state !== es[i] || outs !== eo[i]) begin
            n_fail++;
            $display("FAIL addi step%0d: state=%0d outs=%b, expected state=%0d outs=%b", i, state, outs, es[i], eo[i]);
         end
      end
   endtask

   task automatic test_reset_abort();
      opcode = 6'b100011;
      for (int i = 0; i < 3; i++) begin
         @(posedge clock); @(negedge clock);
      end
      n_checks++;
      if (state !== 4'd4 || outs !== O_MREAD) begin
         n_fail++;
         $display("FAIL abort_pre: state=%0d outs=%b, expected state=4 outs=%b", state, outs, O_MREAD);
      end
      #1 resetN = 1'b0;
      #1;
      n_checks++;
      if (state !== 4'd0 || outs !== O_ZERO) begin
         n_fail++;
         $display("FAIL abort_async: state=%0d outs=%b, expected state=0 outs=%b", state, outs, O_ZERO);
      end
      for (int i = 0; i < 2; i++) begin
         @(negedge clock);
         n_checks++;
         if (writeDataSignal !== 1'b0 || state !== 4'd0) begin
            n_fail++;
            $display("FAIL abort_hold cyc%0d: wds=%b state=%0d, expected wds=0 state=0", i, writeDataSignal, state);
         end
      end
      resetN = 1'b1;
      @(negedge clock);
      n_checks++;
      if (state !== 4'd1 || outs !== O_FETCH) begin
         n_fail++;
         $display("FAIL abort_release: state=%0d outs=%b, expected state=1 outs=%b", state, outs, O_FETCH);
      end
   endtask

   initial begin
      resetN = 1'b0;
      opcode = 6'b000000;
      test_reset();
      test_rtype();
      test_lw_sw();
      test_beq();
      test_illegal_then_jump();
      test_addi();
      test_reset_abort();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
